// File: rtl/vector_sum.sv
// Pipelined unsigned adder tree: reduces DIM packed W_u-bit elements to one
// full-precision sum, one register stage per tree level, one vector per cycle.
module vector_sum #(
    parameter int DIM = 2,
    parameter int W_u = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [DIM*W_u-1:0]            u,
    output logic [W_u+$clog2(DIM)-1:0]    sum,
    output logic                          readEn
);

    localparam int LVL  = $clog2(DIM);
    localparam int LAT  = (LVL < 1) ? 1 : LVL;
    localparam int W_S  = W_u + LVL;
    localparam int NPAD = 1 << LVL;

    // Bit offset of tree level k (1..LVL) inside the flattened tree register;
    // level m holds NPAD>>m entries of W_u+m bits each.
    function automatic int lvlOffset(input int k);
        int acc;
        acc = 0;
        for (int m = 1; m < k; m++) begin
            acc += (NPAD >> m) * (W_u + m);
        end
        return acc;
    endfunction

    logic [LAT-1:0] r_fill;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fill <= '0;
        end else begin
            r_fill <= (r_fill << 1) | LAT'(1);
        end
    end

    assign readEn = r_fill[LAT-1];

    generate
        if (LVL == 0) begin : g_flat
            logic [W_S-1:0] r_sum;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    r_sum <= '0;
                end else begin
                    r_sum <= u;
                end
            end

            assign sum = r_sum;
        end else begin : g_tree
            localparam int TREE_W = lvlOffset(LVL + 1);

            logic [NPAD*W_u-1:0] w_pad;
            logic [TREE_W-1:0]   w_next;
            logic [TREE_W-1:0]   r_tree;

            // Missing elements of a non-power-of-two vector are constant zeros.
            assign w_pad = (NPAD*W_u)'(u);

            for (genvar k = 0; k < LVL; k++) begin : g_lvl
                localparam int WI      = W_u + k;
                localparam int WO      = WI + 1;
                localparam int N       = NPAD >> (k + 1);
                localparam int IN_OFF  = lvlOffset(k);
                localparam int OUT_OFF = lvlOffset(k + 1);

                for (genvar j = 0; j < N; j++) begin : g_node
                    logic [WI-1:0] w_a;
                    logic [WI-1:0] w_b;

                    if (k == 0) begin : g_src_in
                        assign w_a = w_pad[(2*j)*WI +: WI];
                        assign w_b = w_pad[(2*j+1)*WI +: WI];
                    end else begin : g_src_tree
                        assign w_a = r_tree[IN_OFF + (2*j)*WI +: WI];
                        assign w_b = r_tree[IN_OFF + (2*j+1)*WI +: WI];
                    end

                    assign w_next[OUT_OFF + j*WO +: WO] = WO'(w_a) + WO'(w_b);
                end
            end

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    r_tree <= '0;
                end else begin
                    r_tree <= w_next;
                end
            end

            assign sum = r_tree[lvlOffset(LVL) +: W_S];
        end
    endgenerate

endmodule

// File: tb/tb_vector_sum.sv
// Scoreboard bench for vector_sum across four parameterisations sharing one
// clock and reset: DIM=2/W=8, DIM=5/W=8, DIM=4/W=4, DIM=1/W=8.
module tb_vector_sum;

    logic        Clock;
    logic        Reset;
    logic [15:0] u2;
    logic [39:0] u5;
    logic [15:0] u4;
    logic [7:0]  u1;
    logic [8:0]  sum2;
    logic [10:0] sum5;
    logic [5:0]  sum4;
    logic [7:0]  sum1;
    logic        en2, en5, en4, en1;

    int errors = 0;
    int checks = 0;

    logic [63:0] sbQ [4][$];
    logic [63:0] obsSum [4];
    logic        obsEn [4];
    int          latOf [4] = '{1, 3, 2, 1};

    vector_sum #(.DIM(2), .W_u(8)) dut2 (.Clock(Clock), .Reset(Reset), .u(u2), .sum(sum2), .readEn(en2));
    vector_sum #(.DIM(5), .W_u(8)) dut5 (.Clock(Clock), .Reset(Reset), .u(u5), .sum(sum5), .readEn(en5));
    vector_sum #(.DIM(4), .W_u(4)) dut4 (.Clock(Clock), .Reset(Reset), .u(u4), .sum(sum4), .readEn(en4));
    vector_sum #(.DIM(1), .W_u(8)) dut1 (.Clock(Clock), .Reset(Reset), .u(u1), .sum(sum1), .readEn(en1));

    assign obsSum[0] = 64'(sum2);
    assign obsSum[1] = 64'(sum5);
    assign obsSum[2] = 64'(sum4);
    assign obsSum[3] = 64'(sum1);
    assign obsEn[0]  = en2;
    assign obsEn[1]  = en5;
    assign obsEn[2]  = en4;
    assign obsEn[3]  = en1;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [63:0] vecSum(input logic [63:0] v, input int dim, input int w);
        logic [63:0] acc;
        logic [63:0] mask;
        acc  = 64'd0;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < dim; i++) begin
            acc += (v >> (i*w)) & mask;
        end
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a2, input logic [39:0] a5,
                                 input logic [15:0] a4, input logic [7:0] a1);
        @(negedge Clock);
        u2 = a2;
        u5 = a5;
        u4 = a4;
        u1 = a1;
    endtask

    // Push the model sum of whatever each DUT samples at this edge; once a
    // queue is LAT deep the oldest entry is what the DUT must now present.
    always @(posedge Clock) begin
        if (!Reset) begin
            sbQ[0].push_back(vecSum(64'(u2), 2, 8));
            sbQ[1].push_back(vecSum(64'(u5), 5, 8));
            sbQ[2].push_back(vecSum(64'(u4), 4, 4));
            sbQ[3].push_back(vecSum(64'(u1), 1, 8));
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sbQ[i].size() >= latOf[i]) begin
                checkOutput($sformatf("sum%0d", i), obsSum[i], sbQ[i].pop_front());
                checkOutput($sformatf("readEn%0d", i), 64'(obsEn[i]), 64'd1);
            end else begin
                checkOutput($sformatf("fillEn%0d", i), 64'(obsEn[i]), 64'd0);
                if (Reset) begin
                    checkOutput($sformatf("rstSum%0d", i), obsSum[i], 64'd0);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1;
        u2 = '0;
        u5 = '0;
        u4 = '0;
        u1 = '0;
        #2;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("initSum%0d", i), obsSum[i], 64'd0);
            checkOutput($sformatf("initEn%0d", i), 64'(obsEn[i]), 64'd0);
        end
        repeat (2) @(posedge Clock);

        @(negedge Clock);
        Reset = 1'b0;
        u2 = 16'h0801;
        u5 = 40'h0504030201;
        u4 = 16'h1111;
        u1 = 8'hA5;
        applyStimulus(16'hFFFF, 40'hFFFFFFFFFF, 16'hFFFF, 8'hFF);
        applyStimulus(16'h0000, 40'h0000000000, 16'h0000, 8'h00);
        applyStimulus(16'h0102, 40'h0A0B0C0D0E, 16'h8432, 8'h01);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(16'($urandom), 40'({$urandom, $urandom}), 16'($urandom), 8'($urandom));
        end

        // Asynchronous reset between edges while the pipelines are full.
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("asyncSum%0d", i), obsSum[i], 64'd0);
            checkOutput($sformatf("asyncEn%0d", i), 64'(obsEn[i]), 64'd0);
            sbQ[i].delete();
        end
        repeat (2) @(posedge Clock);

        @(negedge Clock);
        Reset = 1'b0;
        u2 = 16'hFF01;
        u5 = 40'hFF00FF0080;
        u4 = 16'hF00F;
        u1 = 8'h5A;
        for (int n = 0; n < 12; n++) begin
            applyStimulus(16'($urandom), 40'({$urandom, $urandom}), 16'($urandom), 8'($urandom));
        end
        repeat (4) @(negedge Clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
